accum_8bit: RTL

//   Sequential accumulator stage wrapped around the team's 8-bit ripple-carry adder.

---
 rtl/accum_8bit_pkg.sv | 15 +
 rtl/accum_8bit_adder.sv | 23 ++
 rtl/accum_8bit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/accum_8bit_pkg.sv
// rtl/accum_8bit_pkg.sv - opcodes and FSM state encoding for the 8-bit accumulator stage
package accum_8bit_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADC  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/accum_8bit_adder.sv
// rtl/accum_8bit_adder.sv - 8-bit ripple-carry adder used by the accumulator stage
module fullAdder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       co
);

  logic [8:0] c;

  always_comb begin
    c   = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[8];
  end

endmodule

// File: rtl/accum_8bit.sv
// rtl/accum_8bit.sv - accumulator stage: accept op, add into acc through the ripple adder, present result
module accum_8bit
  import accum_8bit_pkg::*;
#(
  parameter int         COUNT_W  = 4,
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [7:0]         din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         acc,
  output logic               carry,
  output logic               ovf,
  output logic [COUNT_W-1:0] count
);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [7:0]           din_q, din_d;
  logic [7:0]           acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [7:0]           bop;
  logic                 cin;
  logic [7:0]           sum;
  logic                 co;

  // SUB is acc + ~din + 1, so carry-out reads as "no borrow"
  always_comb begin
    bop = din_q;
    cin = 1'b0;
    case (op_q)
      OP_ADC:  cin = carry_q;
      OP_SUB: begin
        bop = ~din_q;
        cin = 1'b1;
      end
      default: ;
    endcase
  end

  fullAdder8bit u_adder (
    .a   (acc_q),
    .b   (bop),
    .cin (cin),
    .sum (sum),
    .co  (co)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    din_d   = din_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          din_d   = din;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        count_d = count_q + COUNT_W'(1);
        state_d = ST_RESP;
        if (op_q == OP_LOAD) begin
          acc_d   = din_q;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          acc_d   = sum;
          carry_d = co;
          ovf_d   = (acc_q[7] == bop[7]) && (sum[7] != acc_q[7]);
        end
      end
      ST_RESP: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      din_q   <= 8'h00;
      acc_q   <= ACC_INIT;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      din_q   <= din_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_RESP);
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule
